// File: rtl/sort_verifier.sv
// Sequentially reads the sort engine's result memory and reports ordering violations
// between adjacent words, along with a 16-bit checksum of all words read.
module sort_verifier #(
  parameter int unsigned N_WORDS = 256,
  parameter bit          DESCEND = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] Read_data,
  output logic [7:0]  address,
  output logic        read,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_count,
  output logic [7:0]  first_err_addr,
  output logic [15:0] checksum
);

  localparam logic [7:0] LastAddr = 8'(N_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        read_q, read_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [8:0]  err_q, err_d;
  logic [7:0]  first_q, first_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] prev_q, prev_d;
  logic        viol;

  // Equal words never count as a violation in either direction.
  assign viol = DESCEND ? (Read_data > prev_q) : (Read_data < prev_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_d  = read_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    sum_d   = sum_q;
    prev_d  = prev_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = 8'd0;
          read_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 9'd0;
          first_d = 8'd0;
          sum_d   = 16'd0;
        end
      end
      StRun: begin
        // Read_data holds the word for addr_q, issued on the previous edge.
        sum_d  = sum_q + Read_data;
        prev_d = Read_data;
        if ((addr_q != 8'd0) && viol) begin
          err_d = err_q + 9'd1;
          if (err_q == 9'd0) begin
            first_d = addr_q;
          end
        end
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          read_d  = 1'b0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      StDrain: begin
        state_d = StFinish;
        done_d  = 1'b1;
        pass_d  = (err_q == 9'd0);
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= 8'd0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 9'd0;
      first_q <= 8'd0;
      sum_q   <= 16'd0;
      prev_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      sum_q   <= sum_d;
      prev_q  <= prev_d;
    end
  end

  assign address        = addr_q;
  assign read           = read_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign checksum       = sum_q;

endmodule
